// File: rtl/bfp_dot_accumulator.sv
// bfp_dot_accumulator
//
// Block-floating-point multiply-accumulate engine. Sign/magnitude mantissa pairs
// arrive one at a time. The exponent pair is taken from the first element of each
// block. Each pair goes through a MANT_W-cycle shift-add multiplier and is then
// added into a signed accumulator. The last element of a block produces one
// sign/magnitude result together with its combined exponent.
//
// Optional feature macro: BFP_DOT_SAT_EN
//   defined   - the accumulator saturates to +/-(2^ACC_W-1) and out_acc_ovf is sticky
//   undefined - the accumulator wraps modulo 2^(ACC_W+1) and out_acc_ovf is tied 0
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   input element handshake; in_last marks the end of a block
//   a_sign/b_sign       operand signs (1 = negative)
//   a_mant/b_mant       operand magnitudes
//   a_exp/b_exp         block exponents, sampled on the first element only
//   out_valid/out_ready result handshake
//   out_sign/out_mant   sign/magnitude dot product
//   out_exp             clamped combined exponent
//   out_exp_ovf         the exponent was clamped
//   out_acc_ovf         the accumulator saturated during this block
module bfp_dot_accumulator #(
  parameter int unsigned MANT_W   = 8,
  parameter int unsigned EXP_W    = 8,
  parameter int          EXP_BIAS = 127,
  parameter int unsigned ACC_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [EXP_W-1:0]  b_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [ACC_W-1:0]  out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_exp_ovf,
  output logic              out_acc_ovf
);

  localparam int unsigned CNT_W = $clog2(MANT_W + 1);
  localparam int unsigned EW    = EXP_W + 2;
`ifdef BFP_DOT_SAT_EN
  // One spare bit above the accumulator, so that an overflowing sum can still be
  // seen before it is clamped.
  localparam int unsigned SUM_W = ACC_W + 2;
`else
  localparam int unsigned SUM_W = ACC_W + 1;
`endif

  typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

  state_e                  state_q, state_d;
  logic [MANT_W-1:0]       a_mant_q, a_mant_d;
  logic [MANT_W-1:0]       hi_q, hi_d;
  logic [MANT_W-1:0]       lo_q, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    psign_q, psign_d;
  logic                    last_q, last_d;
  logic                    first_q, first_d;
  logic signed [EW-1:0]    e_q, e_d;
  logic signed [ACC_W:0]   acc_q, acc_d;

  logic [MANT_W:0]         add_sum;
  logic signed [SUM_W-1:0] acc_ext, prod_ext, acc_sum;

`ifdef BFP_DOT_SAT_EN
  localparam logic signed [SUM_W-1:0] MaxMag = {2'b00, {ACC_W{1'b1}}};
  localparam logic signed [SUM_W-1:0] MinVal = -MaxMag;
  logic acc_ovf_q, acc_ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_mant_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      psign_q  <= 1'b0;
      last_q   <= 1'b0;
      first_q  <= 1'b1;
      e_q      <= '0;
      acc_q    <= '0;
`ifdef BFP_DOT_SAT_EN
      acc_ovf_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_mant_q <= a_mant_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      psign_q  <= psign_d;
      last_q   <= last_d;
      first_q  <= first_d;
      e_q      <= e_d;
      acc_q    <= acc_d;
`ifdef BFP_DOT_SAT_EN
      acc_ovf_q <= acc_ovf_d;
`endif
    end
  end

  // Shift-add step: conditionally add the multiplicand into the high half, then shift
  // the carry, high and low halves right by one as a single register.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mant_q} : '0);
  end

  // Signed accumulate of +/- the 2*MANT_W-bit unsigned product.
  always_comb begin
    acc_ext  = SUM_W'(acc_q);
    prod_ext = SUM_W'({hi_q, lo_q});
    acc_sum  = psign_q ? (acc_ext - prod_ext) : (acc_ext + prod_ext);
  end

  always_comb begin
    state_d  = state_q;
    a_mant_d = a_mant_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    psign_d  = psign_q;
    last_d   = last_q;
    first_d  = first_q;
    e_d      = e_q;
    acc_d    = acc_q;
`ifdef BFP_DOT_SAT_EN
    acc_ovf_d = acc_ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_mant_d = a_mant;
          hi_d     = '0;
          lo_d     = b_mant;
          cnt_d    = CNT_W'(MANT_W);
          psign_d  = a_sign ^ b_sign;
          last_d   = in_last;
          if (first_q) begin
            e_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - EW'(EXP_BIAS);
          end
          state_d = StMul;
        end
      end
      StMul: begin
        hi_d  = add_sum[MANT_W:1];
        lo_d  = {add_sum[0], lo_q[MANT_W-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StAcc;
      end
      StAcc: begin
`ifdef BFP_DOT_SAT_EN
        if (acc_sum > MaxMag) begin
          acc_d     = MaxMag[ACC_W:0];
          acc_ovf_d = 1'b1;
        end else if (acc_sum < MinVal) begin
          acc_d     = MinVal[ACC_W:0];
          acc_ovf_d = 1'b1;
        end else begin
          acc_d = acc_sum[ACC_W:0];
        end
`else
        acc_d = acc_sum;
`endif
        first_d = 1'b0;
        state_d = last_q ? StOut : StIdle;
      end
      StOut: begin
        if (out_ready) begin
          acc_d   = '0;
          first_d = 1'b1;
`ifdef BFP_DOT_SAT_EN
          acc_ovf_d = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result formatting. Everything is gated by out_valid so that all outputs read 0
  // outside the OUT state.
  logic             acc_neg, acc_zero, e_neg, e_big;
  logic [EXP_W-1:0] exp_val;

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StOut);
    acc_neg   = acc_q[ACC_W];
    acc_zero  = (acc_q == '0);
    e_neg     = e_q[EW-1];
    e_big     = !e_neg && e_q[EXP_W];
    if (e_neg) exp_val = '0;
    else if (e_big) exp_val = '1;
    else exp_val = e_q[EXP_W-1:0];
    out_sign    = out_valid && acc_neg;
    out_mant    = out_valid ? ACC_W'(acc_neg ? -acc_q : acc_q) : '0;
    out_exp     = (out_valid && !acc_zero) ? exp_val : '0;
    out_exp_ovf = out_valid && (e_neg || e_big);
`ifdef BFP_DOT_SAT_EN
    out_acc_ovf = out_valid && acc_ovf_q;
`else
    out_acc_ovf = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bfp_dot_accumulator.sv
// Self-checking bench for bfp_dot_accumulator. It runs with ACC_W=16 so that the
// saturation and wrap behaviour can be reached. The reference model sums the products
// as plain integers and applies clamp or wrap (per BFP_DOT_SAT_EN) after every add.
module tb_bfp_dot_accumulator;
  localparam int MANT_W   = 8;
  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;
  localparam int ACC_W    = 16;
  localparam int RES_W    = ACC_W + EXP_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic              a_sign = 1'b0, b_sign = 1'b0;
  logic [MANT_W-1:0] a_mant = '0, b_mant = '0;
  logic [EXP_W-1:0]  a_exp = '0, b_exp = '0;
  logic              out_valid, out_ready = 1'b0, out_sign, out_exp_ovf, out_acc_ovf;
  logic [ACC_W-1:0]  out_mant;
  logic [EXP_W-1:0]  out_exp;

  int checks = 0;
  int fails  = 0;

  // Element table for the block currently being driven.
  bit e_as[16], e_bs[16];
  int e_am[16], e_bm[16], e_ae[16], e_be[16];

  bfp_dot_accumulator #(
    .MANT_W  (MANT_W),
    .EXP_W   (EXP_W),
    .EXP_BIAS(EXP_BIAS),
    .ACC_W   (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .a_sign     (a_sign),
    .b_sign     (b_sign),
    .a_mant     (a_mant),
    .b_mant     (b_mant),
    .a_exp      (a_exp),
    .b_exp      (b_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_exp_ovf(out_exp_ovf),
    .out_acc_ovf(out_acc_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void set_el(input int i, input bit as, input int am, input bit bs,
                                 input int bm, input int ae, input int be);
    e_as[i] = as; e_am[i] = am; e_bs[i] = bs; e_bm[i] = bm; e_ae[i] = ae; e_be[i] = be;
  endfunction

  // Expected {sign, mant, exp, exp_ovf, acc_ovf} for the first n table entries.
  function automatic logic [RES_W-1:0] model(input int n);
    longint acc, lim, mag, p;
    int     e, ex, emax;
    bit     aovf, eovf, sgn;
    acc  = 0;
    aovf = 0;
    lim  = (longint'(1) << ACC_W) - 1;
    for (int i = 0; i < n; i++) begin
      p = longint'(e_am[i]) * longint'(e_bm[i]);
      if (e_as[i] ^ e_bs[i]) acc = acc - p;
      else acc = acc + p;
`ifdef BFP_DOT_SAT_EN
      if (acc > lim) begin acc = lim; aovf = 1; end
      else if (acc < -lim) begin acc = -lim; aovf = 1; end
`else
      acc = acc & ((longint'(1) << (ACC_W + 1)) - 1);
      if (acc > lim) acc = acc - (longint'(1) << (ACC_W + 1));
`endif
    end
    sgn  = (acc < 0);
    mag  = (sgn ? -acc : acc) & lim;
    e    = e_ae[0] + e_be[0] - EXP_BIAS;
    emax = (1 << EXP_W) - 1;
    eovf = (e < 0) || (e > emax);
    ex   = (e < 0) ? 0 : ((e > emax) ? emax : e);
    if (acc == 0) ex = 0;
    return {sgn, mag[ACC_W-1:0], ex[EXP_W-1:0], eovf, aovf};
  endfunction

  // Offer table entry i; gap counts the cycles in_ready was low before acceptance.
  task automatic send(input int i, input bit last, output bit ok, output int gap);
    a_sign = e_as[i]; b_sign = e_bs[i];
    a_mant = MANT_W'(e_am[i]); b_mant = MANT_W'(e_bm[i]);
    a_exp  = EXP_W'(e_ae[i]);  b_exp  = EXP_W'(e_be[i]);
    in_last = last;
    in_valid = 1'b1;
    ok = 0;
    gap = 0;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (in_ready) ok = 1;
      else gap++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [RES_W-1:0] obs, output bit to, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    to  = !out_valid;
    obs = {out_sign, out_mant, out_exp, out_exp_ovf, out_acc_ovf};
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_block(input int n, output logic [RES_W-1:0] obs, output bit to,
                           output int lat, output int gap);
    bit ok, all_ok;
    all_ok = 1;
    for (int i = 0; i < n; i++) begin
      send(i, i == n - 1, ok, gap);
      all_ok &= ok;
    end
    wait_result(obs, to, lat);
    to |= !all_ok;
    handshake();
  endtask

  task automatic test_reset();
    bit ok;
    int gap;
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_sign, out_mant, out_exp, out_exp_ovf, out_acc_ovf, in_ready}
        !== {{(RES_W + 1){1'b0}}, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got valid=%b mant=%h exp=%h ready=%b, need all 0, ready=1",
               out_valid, out_mant, out_exp, in_ready);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // Leave a nonzero partial sum, then reset while the next element is multiplying.
    set_el(0, 0, 200, 0, 200, 200, 200);
    send(0, 0, ok, gap);
    repeat (MANT_W + 1) @(posedge clk);
    #1;
    send(0, 0, ok, gap);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sign, out_mant, out_exp, out_exp_ovf, out_acc_ovf, in_ready}
        !== {{(RES_W + 1){1'b0}}, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_mul: got valid=%b mant=%h ready=%b, need 0/0/1",
               out_valid, out_mant, in_ready);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_el(0, 0, 3, 0, 5, 130, 127);
    exp_r = model(1);
    run_block(1, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL reset_clean_block: got to=%b %h, need %h", to, obs, exp_r);
    end
  endtask

  task automatic test_single();
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat, gap;
    set_el(0, 0, 3, 0, 5, 130, 127);
    exp_r = model(1);
    run_block(1, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL single_result: got to=%b %h, need %h", to, obs, exp_r);
    end
    checks++;
    if (lat !== MANT_W + 1) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles, need %0d", lat, MANT_W + 1);
    end
  endtask

  task automatic test_four();
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat, gap;
    set_el(0, 0, 200, 0, 100, 140, 120);
    set_el(1, 1, 255, 0, 255, 3, 250);
    set_el(2, 0, 1, 0, 1, 0, 0);
    set_el(3, 1, 10, 1, 10, 255, 255);
    exp_r = model(4);
    run_block(4, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL four_elem_result: got to=%b %h, need %h", to, obs, exp_r);
    end
    checks++;
    if (gap !== MANT_W + 1) begin
      fails++;
      $display("FAIL four_elem_throughput: got %0d not-ready cycles, need %0d", gap, MANT_W + 1);
    end
  endtask

  task automatic test_exp_clamp();
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat, gap;
    set_el(0, 0, 2, 1, 3, 10, 10);
    exp_r = model(1);
    run_block(1, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL exp_clamp_low: got to=%b %h, need %h", to, obs, exp_r);
    end
    set_el(0, 1, 4, 0, 6, 255, 255);
    exp_r = model(1);
    run_block(1, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL exp_clamp_high: got to=%b %h, need %h", to, obs, exp_r);
    end
  endtask

  task automatic test_saturation();
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat, gap;
    for (int i = 0; i < 3; i++) set_el(i, 0, 255, 0, 255, 127, 127);
    exp_r = model(3);
    run_block(3, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL sat_positive: got to=%b %h, need %h", to, obs, exp_r);
    end
    for (int i = 0; i < 3; i++) set_el(i, 1, 255, 0, 255, 127, 127);
    exp_r = model(3);
    run_block(3, obs, to, lat, gap);
    checks++;
    if ({to, obs} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL sat_negative: got to=%b %h, need %h", to, obs, exp_r);
    end
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] obs, exp_r, snap;
    bit to, ok, stable;
    int lat, gap;
    set_el(0, 0, 9, 0, 4, 127, 130);
    exp_r = model(1);
    send(0, 1, ok, gap);
    wait_result(snap, to, lat);
    checks++;
    if ({to, snap} !== {1'b0, exp_r}) begin
      fails++;
      $display("FAIL bp_result: got to=%b %h, need %h", to, snap, exp_r);
    end
    // Offer the next element while the result is stalled; it must wait, not vanish.
    a_sign = 0; b_sign = 0; a_mant = 7; b_mant = 7; a_exp = 127; b_exp = 127;
    in_last = 0;
    in_valid = 1'b1;
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ({out_valid, out_sign, out_mant, out_exp, out_exp_ovf, out_acc_ovf, in_ready}
          !== {1'b1, snap, 1'b0}) stable = 0;
    end
    checks++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall_stable: got stable=%b, need 1", stable);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release: got ready=%b valid=%b, need 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_held: got ready=%b, need 0", in_ready);
    end
    set_el(0, 0, 7, 0, 7, 127, 127);
    set_el(1, 1, 7, 0, 7, 127, 127);
    exp_r = model(2);
    send(1, 1, ok, gap);
    wait_result(obs, to, lat);
    handshake();
    checks++;
    if ({to, ok, obs} !== {2'b01, exp_r}) begin
      fails++;
      $display("FAIL bp_cancellation: got to=%b ok=%b %h, need %h", to, ok, obs, exp_r);
    end
  endtask

  task automatic test_random();
    logic [RES_W-1:0] obs, exp_r;
    bit to;
    int lat, gap, n;
    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        set_el(i, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'($urandom_range(0, 1)),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      exp_r = model(n);
      run_block(n, obs, to, lat, gap);
      checks++;
      if ({to, obs} !== {1'b0, exp_r}) begin
        fails++;
        $display("FAIL random_block_%0d: got to=%b %h, need %h", b, to, obs, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_exp_clamp();
    test_saturation();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
